// File: rtl/fifo_push_arbiter_if.sv
// Producer/FIFO-side signal bundle for the shared FIFO write-port arbiter.
// The arbiter uses the master view; producers and the FIFO use the slave view.
interface fifo_push_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_push;
    logic [DATA_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_full;
    logic                          grant_valid;
    logic [ID_WIDTH-1:0]           grant_id;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_push, fifo_data_in, grant_valid, grant_id
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_push, fifo_data_in, grant_valid, grant_id
    );
endinterface

// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// A winner holds the port for up to MAX_BURST pushes; FIFO full stalls without releasing.

module fifo_push_arbiter_lane #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  owner,
    input  logic                  fifo_full,
    input  logic                  valid,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  ready,
    output logic                  push,
    output logic [DATA_WIDTH-1:0] data_out
);
    assign ready    = owner & ~fifo_full;
    assign push     = ready & valid;
    // Non-owner lanes contribute zero so the top can OR-reduce the payload.
    assign data_out = push ? data : '0;
endmodule

module fifo_push_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    fifo_push_arbiter_if.master bus
);
    localparam int                CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_BURST - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] grant_id;
    logic [ID_WIDTH-1:0] rr_ptr;
    logic                grant_valid;
    logic [CNT_W-1:0]    beat_cnt;

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_data;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] lane_out;
    logic [NUM_REQ-1:0]                 owner_sel;
    logic [NUM_REQ-1:0]                 lane_ready;
    logic [NUM_REQ-1:0]                 lane_push;
    logic [DATA_WIDTH-1:0]              data_or;

    logic                granted;
    logic                push;
    logic                owner_valid;
    logic                rel;
    logic [ID_WIDTH-1:0] next_ptr;
    logic [ID_WIDTH-1:0] search_start;
    logic [ID_WIDTH-1:0] cand;
    logic [ID_WIDTH-1:0] pick_id;
    logic                pick_found;

    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_WIDTH'(s);
    endfunction

    assign lane_data = bus.req_data;
    assign granted   = (state == GRANT);

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign owner_sel[i] = granted && (grant_id == ID_WIDTH'(i));
        fifo_push_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .owner    (owner_sel[i]),
            .fifo_full(bus.fifo_full),
            .valid    (bus.req_valid[i]),
            .data     (lane_data[i]),
            .ready    (lane_ready[i]),
            .push     (lane_push[i]),
            .data_out (lane_out[i])
        );
    end

    always_comb begin
        data_or = '0;
        for (int i = 0; i < NUM_REQ; i++) data_or = data_or | lane_out[i];
    end

    assign push        = |lane_push;
    assign owner_valid = |(owner_sel & bus.req_valid);
    assign next_ptr    = (grant_id == LAST_ID) ? '0 : grant_id + ID_WIDTH'(1);
    // Stalls on full never release: only a final push or a dropped valid ends the burst.
    assign rel         = granted && ((push && (beat_cnt == LAST_BEAT)) || !owner_valid);

    // On release the search starts past the outgoing owner, so re-arbitration has no bubble.
    always_comb begin
        search_start = granted ? next_ptr : rr_ptr;
        pick_found   = 1'b0;
        pick_id      = '0;
        cand         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(search_start, k);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            beat_cnt    <= '0;
            rr_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state       <= GRANT;
                        grant_id    <= pick_id;
                        grant_valid <= 1'b1;
                        beat_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (rel) begin
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        if (pick_found) begin
                            grant_id <= pick_id;
                        end else begin
                            state       <= IDLE;
                            grant_valid <= 1'b0;
                        end
                    end else if (push) begin
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready    = lane_ready;
    assign bus.fifo_push    = push;
    assign bus.fifo_data_in = data_or;
    assign bus.grant_valid  = grant_valid;
    assign bus.grant_id     = grant_id;
endmodule
